clk_tick_sched: RTL and testbench

- Central clock-enable scheduler and reset sequencer for the BLDC/UART fabric.
- After system reset it holds a downstream reset for a fixed count, then releases it.
- It then generates per-channel single-cycle tick strobes (UART baud, PWM/commutation, hall sampling) from one clk.
- Each channel's divisor is reprogrammed at runtime through a valid/ready config port, and the change takes effect glitch-free at that channel's next wrap.

---
 rtl/clk_tick_sched_if.sv | 16 +
 rtl/clk_tick_sched.sv | 132 +++++++++++++
 tb/tb_clk_tick_sched.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/clk_tick_sched_if.sv
// Divisor configuration port of clk_tick_sched.
// Handshake: a request transfers on a rising edge where cfg_valid and cfg_ready are both high.
// The master holds cfg_ch/cfg_div stable while cfg_valid is high. cfg_valid may not depend on cfg_ready.
// cfg_err is an unsolicited one-cycle pulse from the slave.
interface clk_tick_sched_if #(
  parameter int DIV_W = 16
) ();
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_err;

  modport master (output cfg_valid, cfg_ch, cfg_div, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, output cfg_ready, cfg_err);
endinterface

// File: rtl/clk_tick_sched.sv
// Reset sequencer plus per-channel clock-enable tick generator.
// Each channel's divisor can be reprogrammed at runtime and switches only at that channel's wrap.
module clk_tick_sched #(
  parameter int NCH      = 3,
  parameter int DIV_W    = 16,
  parameter int RST_HOLD = 32,
  parameter int DEF_DIV  = 434
) (
  input  logic           clk,
  input  logic           rst,
  output logic           sys_rst_n,
  input  logic [NCH-1:0] ch_en,
  output logic [NCH-1:0] tick,
  output logic           busy,
  output logic [1:0]     dbg_state,
  clk_tick_sched_if.slave cfg
);

  localparam int HW = $clog2(RST_HOLD + 1);
  localparam logic [DIV_W-1:0] DEF = DIV_W'(DEF_DIV);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_UPD  = 2'd2
  } state_t;

  state_t           state;
  logic [HW-1:0]    hold_cnt;
  logic [1:0]       req_ch;
  logic [DIV_W-1:0] req_div;
  logic             req_bad;
  logic             bad;
  logic             running;

  logic [DIV_W-1:0] cnt    [NCH];
  logic [DIV_W-1:0] div    [NCH];
  logic [DIV_W-1:0] shadow [NCH];
  logic [NCH-1:0]   pending;
  logic [NCH-1:0]   wrap;
  logic [NCH-1:0]   wr;

  assign bad       = ({30'd0, cfg.cfg_ch} >= 32'(NCH));
  assign running   = (state != S_HOLD);
  assign busy      = |pending;
  assign dbg_state = state;

  // Control FSM: reset hold, then accept one config request per two cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_HOLD;
      hold_cnt      <= '0;
      sys_rst_n     <= 1'b0;
      cfg.cfg_ready <= 1'b0;
      cfg.cfg_err   <= 1'b0;
      req_ch        <= '0;
      req_div       <= DEF;
      req_bad       <= 1'b0;
    end else begin
      cfg.cfg_err <= 1'b0;
      case (state)
        S_HOLD: begin
          if (hold_cnt == HW'(RST_HOLD - 1)) begin
            state         <= S_RUN;
            sys_rst_n     <= 1'b1;
            cfg.cfg_ready <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        S_RUN: begin
          if (cfg.cfg_valid && cfg.cfg_ready) begin
            req_ch        <= cfg.cfg_ch;
            req_div       <= (cfg.cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg.cfg_div;
            req_bad       <= bad;
            cfg.cfg_err   <= bad;
            cfg.cfg_ready <= 1'b0;
            state         <= S_UPD;
          end
        end
        S_UPD: begin
          state         <= S_RUN;
          cfg.cfg_ready <= 1'b1;
        end
        default: state <= S_HOLD;
      endcase
    end
  end

  always_comb begin
    wrap = '0;
    wr   = '0;
    for (int i = 0; i < NCH; i++) begin
      wrap[i] = ch_en[i] && (cnt[i] == div[i] - DIV_W'(1));
      wr[i]   = (state == S_UPD) && !req_bad && (req_ch == 2'(i));
    end
  end

  // Channel counters. A pending divisor only lands when the counter is at 0 next cycle,
  // so no period is ever truncated or stretched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]    <= '0;
        div[i]    <= DEF;
        shadow[i] <= DEF;
      end
      pending <= '0;
      tick    <= '0;
    end else if (running) begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_en[i]) begin
          cnt[i]  <= wrap[i] ? '0 : cnt[i] + DIV_W'(1);
          tick[i] <= wrap[i];
        end else begin
          cnt[i]  <= '0;
          tick[i] <= 1'b0;
        end
        if (pending[i] && (wrap[i] || !ch_en[i])) begin
          div[i]     <= shadow[i];
          pending[i] <= 1'b0;
        end
        // A fresh write landing on the wrap edge stays pending for the next wrap.
        if (wr[i]) begin
          shadow[i]  <= req_div;
          pending[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_tick_sched.sv
// Directed bench for clk_tick_sched: reset hold, default period, glitch-free reprogramming,
// clamp/error handling, shadow overwrite and mid-operation reset.
module tb_clk_tick_sched;

  localparam int NCH   = 3;
  localparam int DIV_W = 16;

  logic           clk;
  logic           rst;
  logic           sys_rst_n;
  logic [NCH-1:0] ch_en;
  logic [NCH-1:0] tick;
  logic           busy;
  logic [1:0]     dbg_state;
  logic [NCH-1:0] tick_seen;

  int n_chk;
  int n_pass;
  int n;

  clk_tick_sched_if #(.DIV_W(DIV_W)) cfg_bus ();

  clk_tick_sched #(
    .NCH(NCH), .DIV_W(DIV_W), .RST_HOLD(32), .DEF_DIV(434)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sys_rst_n(sys_rst_n),
    .ch_en(ch_en),
    .tick(tick),
    .busy(busy),
    .dbg_state(dbg_state),
    .cfg(cfg_bus)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    tick_seen = tick_seen | tick;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_tick(input int idx, input int budget, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!tick[idx] && cnt < budget);
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [DIV_W-1:0] dv);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_ch    = ch;
    cfg_bus.cfg_div   = dv;
    step();
    cfg_bus.cfg_valid = 1'b0;
    chk("ready_low_after_accept", 32'(cfg_bus.cfg_ready), 0);
    step();
  endtask

  task automatic release_and_wait(output int cnt);
    rst = 1'b1;
    cnt = 0;
    do begin
      step();
      cnt++;
      if (cnt == 5) chk("hold_ready_low", 32'(cfg_bus.cfg_ready), 0);
      if (cnt == 10) cfg_bus.cfg_valid = 1'b0;
    end while (!sys_rst_n && cnt < 40);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    tick_seen = '0;
    rst = 1'b0;
    ch_en = '0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_ch = '0;
    cfg_bus.cfg_div = '0;

    // reset state
    repeat (5) step();
    chk("rst_sys_rst_n", 32'(sys_rst_n), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_ready", 32'(cfg_bus.cfg_ready), 0);
    chk("rst_err", 32'(cfg_bus.cfg_err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_state", 32'(dbg_state), 0);

    // release: downstream reset held for 32 cycles
    tick_seen = '0;
    release_and_wait(n);
    chk("hold_len", 32'(n), 32);
    chk("hold_no_tick", 32'(tick_seen), 0);
    chk("run_ready", 32'(cfg_bus.cfg_ready), 1);
    chk("run_state", 32'(dbg_state), 1);

    // default divisor on ch0
    ch_en = 3'b001;
    tick_seen = '0;
    wait_tick(0, 500, n);
    chk("def_first_tick", 32'(n), 434);
    wait_tick(0, 500, n);
    chk("def_period", 32'(n), 434);
    chk("def_only_ch0", 32'(tick_seen), 32'(3'b001));

    // program ch0 to 10 while disabled, lands on the next edge
    ch_en = 3'b000;
    step();
    cfg_write(2'd0, 16'd10);
    chk("dis_busy_pending", 32'(busy), 1);
    step();
    chk("dis_busy_applied", 32'(busy), 0);
    ch_en = 3'b001;
    wait_tick(0, 50, n);
    chk("div10_first", 32'(n), 10);
    wait_tick(0, 50, n);
    chk("div10_period", 32'(n), 10);

    // mid-period rewrite to 4: current period must still complete at 10
    repeat (3) step();
    cfg_write(2'd0, 16'd4);
    chk("upd_busy", 32'(busy), 1);
    chk("upd_ready_back", 32'(cfg_bus.cfg_ready), 1);
    repeat (4) step();
    chk("upd_busy_hold", 32'(busy), 1);
    chk("upd_no_early_tick", 32'(tick[0]), 0);
    step();
    chk("upd_old_period_end", 32'(tick[0]), 1);
    chk("upd_busy_clear", 32'(busy), 0);
    wait_tick(0, 50, n);
    chk("div4_period_a", 32'(n), 4);
    wait_tick(0, 50, n);
    chk("div4_period_b", 32'(n), 4);

    // clamp: divisor 0 on ch1 becomes 2
    cfg_write(2'd1, 16'd0);
    step();
    ch_en = 3'b011;
    wait_tick(1, 50, n);
    chk("clamp_first", 32'(n), 2);
    wait_tick(1, 50, n);
    chk("clamp_period", 32'(n), 2);

    // invalid channel: error pulse, nothing changes
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_ch = 2'd3;
    cfg_bus.cfg_div = 16'd5;
    step();
    cfg_bus.cfg_valid = 1'b0;
    chk("err_pulse", 32'(cfg_bus.cfg_err), 1);
    chk("err_ready_low", 32'(cfg_bus.cfg_ready), 0);
    step();
    chk("err_pulse_end", 32'(cfg_bus.cfg_err), 0);
    chk("err_no_busy", 32'(busy), 0);
    wait_tick(0, 50, n);
    wait_tick(0, 50, n);
    chk("err_ch0_period", 32'(n), 4);
    wait_tick(1, 50, n);
    wait_tick(1, 50, n);
    chk("err_ch1_period", 32'(n), 2);

    // back-to-back writes to disabled ch2: last value wins
    cfg_write(2'd2, 16'd7);
    cfg_write(2'd2, 16'd9);
    chk("ovw_busy", 32'(busy), 1);
    step();
    chk("ovw_busy_clear", 32'(busy), 0);
    ch_en = 3'b111;
    wait_tick(2, 50, n);
    chk("ovw_first", 32'(n), 9);
    wait_tick(2, 50, n);
    chk("ovw_period", 32'(n), 9);

    // reset with a pending update on ch0
    wait_tick(0, 50, n);
    cfg_write(2'd0, 16'd20);
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1'b0;
    step();
    chk("mid_rst_sys_rst_n", 32'(sys_rst_n), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_tick", 32'(tick), 0);
    chk("mid_rst_ready", 32'(cfg_bus.cfg_ready), 0);
    chk("mid_rst_state", 32'(dbg_state), 0);

    // second release with channels enabled and a request held during hold
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_ch = 2'd0;
    cfg_bus.cfg_div = 16'd5;
    tick_seen = '0;
    release_and_wait(n);
    chk("hold2_len", 32'(n), 32);
    chk("hold2_no_tick", 32'(tick_seen), 0);
    wait_tick(0, 500, n);
    chk("post_rst_ch0_def", 32'(n), 434);
    chk("post_rst_all_def", 32'(tick), 32'(3'b111));
    chk("post_rst_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
